if_id_fetch_queue: RTL

- Instruction prefetch queue between the program counter / instruction memory (IF) and the decode stage (ID).
- Captures each fetched {pc, instruction} pair into a small FIFO and presents the oldest entry to ID.
- Applies the hazard unit's IF/ID write-enable (stall) and the branch/jump flush.
- Drives a ready signal back to IF that gates PC advancement.

---
 rtl/if_pkg.sv | 10 +
 rtl/fetch_fifo_mem.sv | 19 +
 rtl/if_id_fetch_queue.sv | 59 +++++
 3 files changed

// File: rtl/if_pkg.sv
// if_pkg: shared widths, NOP word and fetch entry layout for the IF/ID queue.
package if_pkg;
  localparam int INSTR_W = 32;
  localparam int ADDR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo_mem.sv
// fetch_fifo_mem: unreset entry storage, synchronous write, combinational read.
module fetch_fifo_mem
  import if_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [PTR_W-1:0]              wr_ptr,
  input  logic [$bits(fetch_entry_t)-1:0] wr_data,
  input  logic [PTR_W-1:0]              rd_ptr,
  output logic [$bits(fetch_entry_t)-1:0] rd_data
);
  logic [$bits(fetch_entry_t)-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[wr_ptr] <= wr_data;
  assign rd_data = mem[rd_ptr];
endmodule

// File: rtl/if_id_fetch_queue.sv
// if_id_fetch_queue: prefetch FIFO between fetch and decode with stall, flush and IF backpressure.
module if_id_fetch_queue
  import if_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter logic [31:0] NOP_INSTR = if_pkg::NOP_INSTR
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      if_pc,
  input  logic [31:0]      if_instr,
  input  logic             if_valid,
  output logic             if_ready,
  input  logic             c_IFIDWrite,
  input  logic             c_IFFlush,
  output logic [31:0]      id_pc,
  output logic [31:0]      id_pc_plus4,
  output logic [31:0]      id_instr,
  output logic             id_valid,
  output logic [PTR_W:0]   count
);
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic enq, deq;
  fetch_entry_t wr_entry, head;
  assign if_ready = count != (PTR_W+1)'(DEPTH);
  assign id_valid = count != '0;
  // flush outranks both sides so a dropped fetch never lands in the queue
  assign enq = if_valid & if_ready & ~c_IFFlush;
  assign deq = c_IFIDWrite & id_valid & ~c_IFFlush;
  assign wr_entry = '{pc: if_pc, instr: if_instr};
  fetch_fifo_mem #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_mem (
    .clk(clk),
    .we(enq),
    .wr_ptr(wr_ptr),
    .wr_data(wr_entry),
    .rd_ptr(rd_ptr),
    .rd_data(head)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (c_IFFlush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + (PTR_W+1)'(enq) - (PTR_W+1)'(deq);
    end
  always_comb begin
    id_pc = id_valid ? head.pc : '0;
    id_instr = id_valid ? head.instr : NOP_INSTR;
    id_pc_plus4 = id_pc + 32'd4;
  end
endmodule
